itch_parse_dispatcher: RTL and testbench

ITCH_PARSE_DISPATCHER -- requirements
Module: itch_parse_dispatcher

---
 rtl/itch_pkg.sv | 30 +++
 rtl/itch_rr_arbiter.sv | 56 +++++
 rtl/itch_parse_dispatcher.sv | 164 ++++++++++++++++
 tb/tb_itch_parse_dispatcher.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/itch_pkg.sv
// Shared types and constants for the ITCH parse dispatcher: message-type bytes,
// dispatcher FSM states and error-flag bit positions.
package itch_pkg;

  parameter int unsigned TRK_W_DEF = 6;

  typedef enum logic [7:0] {
    MT_SYSTEM    = 8'h53,
    MT_STOCK_DIR = 8'h52,
    MT_ADD       = 8'h41,
    MT_ADD_MPID  = 8'h46,
    MT_EXEC      = 8'h45,
    MT_CANCEL    = 8'h58,
    MT_DELETE    = 8'h44,
    MT_REPLACE   = 8'h55,
    MT_TRADE     = 8'h50
  } msg_type_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_RUN,
    ST_DONE
  } state_e;

  parameter int unsigned ERR_COLL = 0;
  parameter int unsigned ERR_MASK = 1;
  parameter int unsigned ERR_TMO  = 2;

endpackage

// File: rtl/itch_rr_arbiter.sv
// Channel-end arbiter: fixed priority (lowest index) or round-robin with a
// pointer that moves to winner+1 whenever a grant is consumed.
module itch_rr_arbiter #(
  parameter int unsigned N_CH     = 8,
  parameter int unsigned ARB_MODE = 0,
  localparam int unsigned IDX_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  req_i,
  input  logic             adv_i,
  output logic [N_CH-1:0]  gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             multi_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             found;
  int unsigned      rank;
  int unsigned      win;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  // Rank is the distance from the pointer; scanning ranks in order keeps all
  // request selects at constant indices.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    rank  = 0;
    win   = 0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      for (int unsigned k = 0; k < N_CH; k++) begin
        rank = (ARB_MODE == 1) ? (k + N_CH - 32'(ptr_q)) % N_CH : k;
        if (!found && req_i[k] && rank == i) begin
          found    = 1'b1;
          gnt_o[k] = 1'b1;
          idx_o    = IDX_W'(k);
          win      = k;
        end
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (ARB_MODE == 1 && adv_i && found)
      ptr_d = (win + 1 == N_CH) ? '0 : IDX_W'(win + 1);
  end

  assign multi_o = (req_i & (req_i - N_CH'(1))) != '0;

endmodule

// File: rtl/itch_parse_dispatcher.sv
// Session dispatcher: restarts the type decoder after each parser channel end,
// counts completed messages per channel and flags collisions/masked ends/timeouts.
module itch_parse_dispatcher
  import itch_pkg::*;
#(
  parameter int unsigned N_CH        = 8,
  parameter int unsigned TRK_W       = TRK_W_DEF,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned ARB_MODE    = 0,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [15:0]            msg_count_i,
  input  logic [TRK_W-1:0]       init_tracker_i,
  input  logic [N_CH-1:0]        ch_end_i,
  input  logic [N_CH*TRK_W-1:0]  ch_tracker_i,
  input  logic [N_CH-1:0]        ch_mask_i,
  input  logic [3:0]             cnt_sel_i,
  output logic                   dec_start_o,
  output logic [TRK_W-1:0]       dec_tracker_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [15:0]            msgs_done_o,
  output logic [CNT_W-1:0]       cnt_rd_o,
  output logic [2:0]             err_o
);

  localparam int unsigned IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYC + 1);

  state_e           state_q, state_d;
  logic [15:0]      expect_q, expect_d;
  logic [15:0]      done_cnt_q, done_cnt_d;
  logic [TRK_W-1:0] trk_q, trk_d;
  logic             relaunch_q, relaunch_d;
  logic             zero_done_q, zero_done_d;
  logic [2:0]       err_q, err_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];

  logic [N_CH-1:0]  req, gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             multi, win;
  logic [TRK_W-1:0] win_trk;
  logic [16:0]      done_inc;

  assign req = (state_q == ST_RUN) ? (ch_end_i & ch_mask_i) : '0;
  assign win = |gnt;

  itch_rr_arbiter #(
    .N_CH    (N_CH),
    .ARB_MODE(ARB_MODE)
  ) u_arb (
    .clk    (clk),
    .rst_n  (rst),
    .req_i  (req),
    .adv_i  (win),
    .gnt_o  (gnt),
    .idx_o  (gnt_idx),
    .multi_o(multi)
  );

  always_comb begin
    win_trk = '0;
    for (int unsigned k = 0; k < N_CH; k++)
      if (gnt_idx == IDX_W'(k)) win_trk = ch_tracker_i[k*TRK_W +: TRK_W];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      expect_q    <= '0;
      done_cnt_q  <= '0;
      trk_q       <= '0;
      relaunch_q  <= 1'b0;
      zero_done_q <= 1'b0;
      err_q       <= '0;
      wd_q        <= '0;
      for (int unsigned k = 0; k < N_CH; k++) cnt_q[k] <= '0;
    end else begin
      expect_q    <= expect_d;
      done_cnt_q  <= done_cnt_d;
      trk_q       <= trk_d;
      relaunch_q  <= relaunch_d;
      zero_done_q <= zero_done_d;
      err_q       <= err_d;
      wd_q        <= wd_d;
      for (int unsigned k = 0; k < N_CH; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  always_comb begin
    state_d     = state_q;
    expect_d    = expect_q;
    done_cnt_d  = done_cnt_q;
    trk_d       = trk_q;
    relaunch_d  = 1'b0;
    zero_done_d = 1'b0;
    err_d       = err_q;
    wd_d        = wd_q;
    cnt_d       = cnt_q;
    done_inc    = {1'b0, done_cnt_q} + 17'd1;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          done_cnt_d = '0;
          err_d      = '0;
          wd_d       = '0;
          expect_d   = msg_count_i;
          trk_d      = init_tracker_i;
          for (int unsigned k = 0; k < N_CH; k++) cnt_d[k] = '0;
          if (msg_count_i == '0) zero_done_d = 1'b1;
          else                   state_d     = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        state_d = ST_RUN;
        wd_d    = WD_W'(1);
      end
      ST_RUN: begin
        if ((ch_end_i & ~ch_mask_i) != '0) err_d[ERR_MASK] = 1'b1;
        if (multi)                         err_d[ERR_COLL] = 1'b1;
        // wd holds cycles elapsed since the last decoder restart
        wd_d = relaunch_q ? WD_W'(1) : wd_q + WD_W'(1);
        if (win) begin
          done_cnt_d = done_inc[15:0];
          for (int unsigned k = 0; k < N_CH; k++)
            if (gnt[k] && cnt_q[k] != '1) cnt_d[k] = cnt_q[k] + CNT_W'(1);
          if (done_inc >= {1'b0, expect_q}) begin
            state_d = ST_DONE;
          end else begin
            relaunch_d = 1'b1;
            trk_d      = win_trk;
          end
        end else if (wd_d >= WD_W'(TIMEOUT_CYC)) begin
          err_d[ERR_TMO] = 1'b1;
          state_d        = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o        = (state_q == ST_LAUNCH) || (state_q == ST_RUN);
    dec_start_o   = (state_q == ST_LAUNCH) || relaunch_q;
    dec_tracker_o = dec_start_o ? trk_q : '0;
    done_o        = (state_q == ST_DONE) || zero_done_q;
    msgs_done_o   = done_cnt_q;
    err_o         = err_q;
    cnt_rd_o      = '0;
    for (int unsigned k = 0; k < N_CH; k++)
      if (cnt_sel_i == 4'(k)) cnt_rd_o = cnt_q[k];
  end

endmodule

// File: tb/tb_itch_parse_dispatcher.sv
// Scoreboard bench: two dispatchers (fixed priority and round-robin) share stimulus;
// expected decoder-restart/done events are queued per instance and checked by a monitor.
module tb_itch_parse_dispatcher;

  localparam int EV_DEC  = 1;
  localparam int EV_DONE = 2;

  typedef struct {
    int kind;
    int val;
    int cyc;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [15:0] msg_count_i;
  logic [5:0]  init_tracker_i;
  logic [7:0]  ch_end_i;
  logic [47:0] ch_tracker_i;
  logic [7:0]  ch_mask_i;
  logic [3:0]  cnt_sel_i;

  logic        fp_ds, fp_busy, fp_done, rr_ds, rr_busy, rr_done;
  logic [5:0]  fp_trk, rr_trk;
  logic [15:0] fp_msgs, rr_msgs, fp_cnt, rr_cnt;
  logic [2:0]  fp_err, rr_err;

  ev_t q0[$];
  ev_t q1[$];
  int  n_chk = 0;
  int  n_fail = 0;
  int  cyc = 0;
  int  trkv[8] = '{17, 3, 9, 7, 11, 33, 21, 40};

  itch_parse_dispatcher #(.N_CH(8), .TRK_W(6), .CNT_W(16), .ARB_MODE(0), .TIMEOUT_CYC(16)) u_fp (
    .clk(clk), .rst(rst), .start_i(start_i), .msg_count_i(msg_count_i),
    .init_tracker_i(init_tracker_i), .ch_end_i(ch_end_i), .ch_tracker_i(ch_tracker_i),
    .ch_mask_i(ch_mask_i), .cnt_sel_i(cnt_sel_i), .dec_start_o(fp_ds),
    .dec_tracker_o(fp_trk), .busy_o(fp_busy), .done_o(fp_done), .msgs_done_o(fp_msgs),
    .cnt_rd_o(fp_cnt), .err_o(fp_err));

  itch_parse_dispatcher #(.N_CH(8), .TRK_W(6), .CNT_W(16), .ARB_MODE(1), .TIMEOUT_CYC(16)) u_rr (
    .clk(clk), .rst(rst), .start_i(start_i), .msg_count_i(msg_count_i),
    .init_tracker_i(init_tracker_i), .ch_end_i(ch_end_i), .ch_tracker_i(ch_tracker_i),
    .ch_mask_i(ch_mask_i), .cnt_sel_i(cnt_sel_i), .dec_start_o(rr_ds),
    .dec_tracker_o(rr_trk), .busy_o(rr_busy), .done_o(rr_done), .msgs_done_o(rr_msgs),
    .cnt_rd_o(rr_cnt), .err_o(rr_err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push(input int d, input int kind, input int val, input int c);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = c;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  function automatic void push_both(input int kind, input int val, input int c);
    push(0, kind, val, c);
    push(1, kind, val, c);
  endfunction

  task automatic mon(input int d, input logic ds, input logic dn,
                     input logic [5:0] trk, input logic [15:0] md);
    ev_t e;
    int  k;
    if (!(ds || dn)) return;
    k = ds ? EV_DEC : EV_DONE;
    check($sformatf("d%0d_dec_done_overlap", d), int'(ds & dn), 0);
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      n_chk++;
      n_fail++;
      $display("FAIL d%0d_unexpected: got event kind %0d at cycle %0d, want none", d, k, cyc);
      return;
    end
    if (d == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    check($sformatf("d%0d_ev_kind", d), k, e.kind);
    check($sformatf("d%0d_ev_cycle", d), cyc, e.cyc);
    check($sformatf("d%0d_ev_value", d), ds ? int'(trk) : int'(md), e.val);
  endtask

  always @(negedge clk) begin
    mon(0, fp_ds, fp_done, fp_trk, fp_msgs);
    mon(1, rr_ds, rr_done, rr_trk, rr_msgs);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_sess(input int count, input int init);
    start_i        = 1'b1;
    msg_count_i    = 16'(count);
    init_tracker_i = 6'(init);
    if (count != 0) push_both(EV_DEC, init, cyc + 1);
    else            push_both(EV_DONE, 0, cyc + 1);
    tick();
    start_i = 1'b0;
  endtask

  task automatic pulse_end(input logic [7:0] ends);
    ch_end_i = ends;
    tick();
    ch_end_i = '0;
  endtask

  task automatic check_cnt(input string name, input int sel, input int exp_fp, input int exp_rr);
    cnt_sel_i = 4'(sel);
    #1;
    check({name, "_fp"}, int'(fp_cnt), exp_fp);
    check({name, "_rr"}, int'(rr_cnt), exp_rr);
  endtask

  task automatic check_both(input string name, input int act_fp, input int act_rr, input int exp);
    check({name, "_fp"}, act_fp, exp);
    check({name, "_rr"}, act_rr, exp);
  endtask

  initial begin
    rst = 1'b0; start_i = 1'b0; msg_count_i = '0; init_tracker_i = '0;
    ch_end_i = '0; ch_mask_i = 8'hFF; cnt_sel_i = '0;
    for (int k = 0; k < 8; k++) ch_tracker_i[k*6 +: 6] = 6'(trkv[k]);
    #12;
    check("rst_outputs", int'({fp_ds, fp_busy, fp_done, rr_ds, rr_busy, rr_done}), 0);
    check_both("rst_msgs", int'(fp_msgs), int'(rr_msgs), 0);
    check_both("rst_err", int'(fp_err), int'(rr_err), 0);
    check_both("rst_trk", int'(fp_trk), int'(rr_trk), 0);
    tick();
    rst = 1'b1;
    tick();

    // zero-count start: done next cycle, never busy
    start_sess(0, 0);
    check_both("zero_busy", int'(fp_busy), int'(rr_busy), 0);
    tick();

    // basic three-message session, with an ignored start while running
    start_sess(3, 5);
    check_both("s1_busy_launch", int'(fp_busy), int'(rr_busy), 1);
    tick();
    push_both(EV_DEC, 9, cyc + 1);
    pulse_end(8'h04);
    start_i = 1'b1; msg_count_i = 16'd7;
    tick();
    start_i = 1'b0;
    push_both(EV_DEC, 17, cyc + 1);
    pulse_end(8'h01);
    push_both(EV_DONE, 3, cyc + 1);
    pulse_end(8'h20);
    tick();
    check_both("s1_msgs", int'(fp_msgs), int'(rr_msgs), 3);
    check_both("s1_err", int'(fp_err), int'(rr_err), 0);
    check_both("s1_busy_idle", int'(fp_busy), int'(rr_busy), 0);
    check_cnt("s1_cnt_ch2", 2, 1, 1);
    check_cnt("s1_cnt_ch5", 5, 1, 1);
    check_cnt("s1_cnt_ch1", 1, 0, 0);
    pulse_end(8'h01);
    check_both("s1_idle_end_err", int'(fp_err), int'(rr_err), 0);
    check_both("s1_idle_end_msgs", int'(fp_msgs), int'(rr_msgs), 3);

    // collisions ch1+ch3: fixed priority takes ch1 twice, round-robin alternates
    start_sess(3, 2);
    tick();
    push(0, EV_DEC, 3, cyc + 1);
    push(1, EV_DEC, 3, cyc + 1);
    pulse_end(8'h0A);
    push(0, EV_DEC, 3, cyc + 1);
    push(1, EV_DEC, 7, cyc + 1);
    pulse_end(8'h0A);
    check_both("s2_msgs", int'(fp_msgs), int'(rr_msgs), 2);
    check_both("s2_err_coll", int'(fp_err), int'(rr_err), 1);
    push_both(EV_DONE, 3, cyc + 1);
    pulse_end(8'h40);
    tick();
    check_cnt("s2_cnt_ch1", 1, 2, 1);
    check_cnt("s2_cnt_ch3", 3, 0, 1);

    // masked channel 0
    ch_mask_i = 8'hFE;
    start_sess(2, 1);
    tick();
    pulse_end(8'h01);
    tick();
    check_both("s3_err_mask", int'(fp_err), int'(rr_err), 2);
    check_both("s3_busy_run", int'(fp_busy), int'(rr_busy), 1);
    check_both("s3_msgs0", int'(fp_msgs), int'(rr_msgs), 0);
    push_both(EV_DEC, 9, cyc + 1);
    pulse_end(8'h05);
    check_both("s3_msgs1", int'(fp_msgs), int'(rr_msgs), 1);
    check_both("s3_err_nocoll", int'(fp_err), int'(rr_err), 2);
    push_both(EV_DONE, 2, cyc + 1);
    pulse_end(8'h10);
    tick();
    ch_mask_i = 8'hFF;

    // watchdog: done on the 16th cycle after the launch restart
    start_sess(5, 12);
    push_both(EV_DONE, 0, cyc + 16);
    repeat (20) tick();
    check_both("s4_err_tmo", int'(fp_err), int'(rr_err), 4);
    check_both("s4_busy", int'(fp_busy), int'(rr_busy), 0);

    // reset in the middle of a session
    start_sess(4, 3);
    tick();
    push_both(EV_DEC, 7, cyc + 1);
    pulse_end(8'h08);
    tick();
    rst = 1'b0;
    #1;
    check("s5_rst_ctrl", int'({fp_ds, fp_busy, fp_done, rr_ds, rr_busy, rr_done}), 0);
    check_both("s5_rst_msgs", int'(fp_msgs), int'(rr_msgs), 0);
    check_cnt("s5_rst_cnt_ch3", 3, 0, 0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    start_sess(1, 4);
    tick();
    push_both(EV_DONE, 1, cyc + 1);
    pulse_end(8'h80);
    tick();
    check_both("s5_clean_msgs", int'(fp_msgs), int'(rr_msgs), 1);
    check_both("s5_clean_err", int'(fp_err), int'(rr_err), 0);
    check_cnt("s5_clean_cnt_ch7", 7, 1, 1);
    repeat (3) tick();

    check("q_fp_drained", q0.size(), 0);
    check("q_rr_drained", q1.size(), 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
